// File: rtl/phase_sweep_ctrl.sv
// PLL dynamic-phase sweep controller: steps the PLL phase one position at a time and records one echo sample per position.
// Build option PHASE_SWEEP_BIDIR_EN: alternate sweep direction each run instead of returning to the origin.
module phase_sweep_ctrl #(
    parameter int MAX_STEPS     = 128,
    parameter int SETTLE_CYCLES = 64,
    parameter int PLL_TIMEOUT   = 255
) (
    input  logic                 clk100,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 pll_phasestep,
    output logic                 pll_phaseupdown,
    input  logic                 pll_phasedone,
    output logic                 sample_req,
    input  logic                 sample_ack,
    input  logic                 sample_bit,
    output logic [MAX_STEPS-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [7:0]           step_idx,
    output logic                 busy,
    output logic                 error
);

    typedef enum logic [3:0] {
        IDLE, SAMPLE, WAIT_SAMPLE, STEP_REQ, STEP_ACK, STEP_DONE, SETTLE, RETURN, DONE
    } state_t;

    localparam logic [7:0]  LAST_IDX    = 8'(MAX_STEPS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST    = 16'(PLL_TIMEOUT - 1);

    state_t               state_reg;
    logic [15:0]          cnt_reg;
    logic [1:0]           arm_reg;
    logic [7:0]           step_idx_reg;
    logic [MAX_STEPS-1:0] result_reg;
    logic                 phasestep_reg;
    logic                 updown_reg;
    logic                 sample_req_reg;
    logic                 result_valid_reg;
    logic                 busy_reg;
    logic                 error_reg;
    logic                 wr_en;
    logic                 sweep_end;
    logic [MAX_STEPS-1:0] bit_sel;

    assign wr_en = (state_reg == WAIT_SAMPLE) && sample_ack;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_STEPS; gi++) begin : g_sel
            assign bit_sel[gi] = (step_idx_reg == 8'(gi));
        end
    endgenerate

`ifdef PHASE_SWEEP_BIDIR_EN
    logic dir_reg;
    assign sweep_end = dir_reg ? (step_idx_reg == 8'd0) : (step_idx_reg == LAST_IDX);
`else
    assign sweep_end = (step_idx_reg == LAST_IDX);
`endif

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            result_reg <= '0;
        end else if (wr_en) begin
            result_reg <= (result_reg & ~bit_sel) | (bit_sel & {MAX_STEPS{sample_bit}});
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            arm_reg          <= '0;
            step_idx_reg     <= '0;
            phasestep_reg    <= 1'b0;
            updown_reg       <= 1'b0;
            sample_req_reg   <= 1'b0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            error_reg        <= 1'b0;
`ifdef PHASE_SWEEP_BIDIR_EN
            dir_reg          <= 1'b0;
`endif
        end else begin
            // start is only honoured once this has filled, keeping the first transition off the first two edges
            arm_reg        <= {arm_reg[0], 1'b1};
            sample_req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    result_valid_reg <= 1'b0;
                    step_idx_reg     <= '0;
                    if (start && !error_reg && arm_reg[1]) begin
                        state_reg <= SAMPLE;
                        busy_reg  <= 1'b1;
`ifdef PHASE_SWEEP_BIDIR_EN
                        step_idx_reg <= dir_reg ? LAST_IDX : 8'd0;
`endif
                    end
                end
                SAMPLE: begin
                    sample_req_reg <= 1'b1;
                    state_reg      <= WAIT_SAMPLE;
                end
                WAIT_SAMPLE: begin
                    if (sample_ack) begin
                        if (sweep_end) begin
`ifdef PHASE_SWEEP_BIDIR_EN
                            state_reg        <= DONE;
                            result_valid_reg <= 1'b1;
`else
                            state_reg <= RETURN;
`endif
                        end else begin
                            state_reg <= STEP_REQ;
`ifdef PHASE_SWEEP_BIDIR_EN
                            updown_reg <= !dir_reg;
`else
                            updown_reg <= 1'b1;
`endif
                        end
                    end
                end
                STEP_REQ: begin
                    phasestep_reg <= 1'b1;
                    cnt_reg       <= '0;
                    state_reg     <= STEP_ACK;
                end
                STEP_ACK: begin
                    if (!pll_phasedone) begin
                        phasestep_reg <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= STEP_DONE;
                    end else if (cnt_reg == TMO_LAST) begin
                        error_reg     <= 1'b1;
                        phasestep_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        step_idx_reg  <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                STEP_DONE: begin
                    if (pll_phasedone) begin
                        cnt_reg <= '0;
                        if (updown_reg) begin
                            if (step_idx_reg != LAST_IDX) step_idx_reg <= step_idx_reg + 8'd1;
                        end else begin
                            if (step_idx_reg != 8'd0) step_idx_reg <= step_idx_reg - 8'd1;
                        end
`ifdef PHASE_SWEEP_BIDIR_EN
                        state_reg <= SETTLE;
`else
                        state_reg <= updown_reg ? SETTLE : RETURN;
`endif
                    end else if (cnt_reg == TMO_LAST) begin
                        error_reg     <= 1'b1;
                        phasestep_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        step_idx_reg  <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                RETURN: begin
                    if (step_idx_reg != 8'd0) begin
                        updown_reg <= 1'b0;
                        state_reg  <= STEP_REQ;
                    end else begin
                        result_valid_reg <= 1'b1;
                        state_reg        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                        step_idx_reg     <= '0;
                        state_reg        <= IDLE;
`ifdef PHASE_SWEEP_BIDIR_EN
                        dir_reg          <= !dir_reg;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pll_phasestep   = phasestep_reg;
    assign pll_phaseupdown = updown_reg;
    assign sample_req      = sample_req_reg;
    assign result          = result_reg;
    assign result_valid    = result_valid_reg;
    assign step_idx        = step_idx_reg;
    assign busy            = busy_reg;
    assign error           = error_reg;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Bench for phase_sweep_ctrl with a 3-cycle PLL model, an echo responder and shift/result scoreboards.
module tb_phase_sweep_ctrl;
    localparam int MS = 4;
    localparam int SC = 4;
    localparam int PT = 255;

    logic          clk100 = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          pll_phasestep, pll_phaseupdown;
    logic          pll_phasedone;
    logic          sample_req;
    logic          sample_ack, sample_bit;
    logic [MS-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [7:0]    step_idx;
    logic          busy, error;

    int   total = 0;
    int   bad = 0;
    logic pd_m;
    int   lat_m;
    logic ack_m, bit_m;
    logic spur_ack = 1'b0, spur_bit = 1'b0;
    logic invert = 1'b0;
    logic pll_dead = 1'b0;
    logic sb_on = 1'b1;
    logic prev_step = 1'b0;
    logic          exp_dir_q[$];
    logic [MS-1:0] exp_res_q[$];

    assign pll_phasedone = pd_m;
    assign sample_ack    = ack_m | spur_ack;
    assign sample_bit    = spur_ack ? spur_bit : bit_m;

    always #5 clk100 = ~clk100;

    phase_sweep_ctrl #(.MAX_STEPS(MS), .SETTLE_CYCLES(SC), .PLL_TIMEOUT(PT)) dut (
        .clk100(clk100), .reset_n(reset_n), .start(start),
        .pll_phasestep(pll_phasestep), .pll_phaseupdown(pll_phaseupdown),
        .pll_phasedone(pll_phasedone), .sample_req(sample_req),
        .sample_ack(sample_ack), .sample_bit(sample_bit),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .step_idx(step_idx), .busy(busy), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // PLL: phasedone drops one cycle after phasestep is seen and stays low for 3 cycles
    always @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            pd_m  <= 1'b1;
            lat_m <= 0;
        end else if (lat_m != 0) begin
            lat_m <= lat_m - 1;
            if (lat_m == 1) pd_m <= 1'b1;
        end else if (pll_phasestep && pd_m && !pll_dead) begin
            pd_m  <= 1'b0;
            lat_m <= 3;
        end
    end

    always @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            ack_m <= 1'b0;
            bit_m <= 1'b0;
        end else begin
            ack_m <= sample_req;
            bit_m <= step_idx[0] ^ invert;
        end
    end

    always @(negedge clk100) begin
        if (sb_on && pll_phasestep && !prev_step) begin
            chk("shift_expected", 32'(exp_dir_q.size() > 0), 1);
            if (exp_dir_q.size() > 0) chk("shift_dir", 32'(pll_phaseupdown), 32'(exp_dir_q.pop_front()));
        end
        prev_step <= pll_phasestep;
    end

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk100);
        reset_n = 1'b1;
    endtask

    task automatic expect_sweep(input int ups, input int downs, input logic [MS-1:0] res);
        for (int i = 0; i < ups; i++) exp_dir_q.push_back(1'b1);
        for (int i = 0; i < downs; i++) exp_dir_q.push_back(1'b0);
        exp_res_q.push_back(res);
    endtask

    task automatic finish_sweep(input logic [7:0] exp_idx);
        int n;
        logic [MS-1:0] er;
        n = 0;
        while (result_valid !== 1'b1 && n < 1000) begin
            @(negedge clk100);
            n++;
        end
        chk("valid_seen", 32'(result_valid), 1);
        er = exp_res_q.pop_front();
        $display("sweep done: result=%b expected=%b step_idx=%0d", result, er, step_idx);
        chk("result", 32'(result), 32'(er));
        chk("shifts_left", 32'(exp_dir_q.size()), 0);
        chk("done_idx", 32'(step_idx), 32'(exp_idx));
        chk("done_busy", 32'(busy), 1);
        repeat (10) begin
            @(negedge clk100);
            chk("hold_valid", 32'(result_valid), 1);
            chk("hold_result", 32'(result), 32'(er));
        end
        result_ready = 1'b1;
        @(negedge clk100);
        result_ready = 1'b0;
        chk("accept_valid", 32'(result_valid), 0);
        chk("accept_busy", 32'(busy), 0);
    endtask

    task automatic wait_step(input logic lvl, input string tag);
        int n;
        n = 0;
        while (pll_phasestep !== lvl && n < 300) begin
            @(negedge clk100);
            n++;
        end
        chk(tag, 32'(pll_phasestep), 32'(lvl));
    endtask

    initial begin
        int n;
        @(negedge clk100);
        chk("reset_outs", 32'({pll_phasestep, pll_phaseupdown, sample_req, result,
                               result_valid, step_idx, busy, error}), 0);
        do_reset();

        // sweep 1, start held from reset release
`ifdef PHASE_SWEEP_BIDIR_EN
        expect_sweep(3, 0, 4'b1010);
`else
        expect_sweep(3, 3, 4'b1010);
`endif
        start = 1'b1;
        @(negedge clk100);
        chk("early_edge1", 32'(busy), 0);
        @(negedge clk100);
        chk("early_edge2", 32'(busy), 0);
        @(negedge clk100);
        chk("start_edge3", 32'(busy), 1);
        start = 1'b0;

        // spurious ack and start pulse during the first SETTLE
        n = 0;
        while (step_idx !== 8'd1 && n < 300) begin
            @(negedge clk100);
            n++;
        end
        chk("reach_settle", 32'(step_idx), 1);
        spur_ack = 1'b1;
        spur_bit = 1'b1;
        start = 1'b1;
        @(negedge clk100);
        spur_ack = 1'b0;
        start = 1'b0;
        chk("spur_ack_ignored", 32'(result), 0);
`ifdef PHASE_SWEEP_BIDIR_EN
        finish_sweep(8'd3);
`else
        finish_sweep(8'd0);
`endif
        repeat (20) @(negedge clk100);
        chk("start_not_queued", 32'(busy), 0);

        // sweep 2, inverted echo pattern
        invert = 1'b1;
`ifdef PHASE_SWEEP_BIDIR_EN
        expect_sweep(0, 3, 4'b0101);
`else
        expect_sweep(3, 3, 4'b0101);
`endif
        start = 1'b1;
        @(negedge clk100);
        start = 1'b0;
        finish_sweep(8'd0);

        // reset while the shift is completing (STEP_DONE)
        sb_on = 1'b0;
        start = 1'b1;
        @(negedge clk100);
        start = 1'b0;
        wait_step(1'b1, "step_rise");
        wait_step(1'b0, "step_fall");
        chk("in_step_done", 32'(pll_phasedone), 0);
        reset_n = 1'b0;
        #1;
        chk("rst_step_done_outs", 32'({pll_phasestep, pll_phaseupdown, sample_req, result,
                                       result_valid, step_idx, busy, error}), 0);
        do_reset();

        // reset while pll_phasestep is high drops it at once
        repeat (2) @(negedge clk100);
        start = 1'b1;
        @(negedge clk100);
        start = 1'b0;
        wait_step(1'b1, "step_rise2");
        reset_n = 1'b0;
        #1;
        chk("rst_async_step", 32'(pll_phasestep), 0);
        do_reset();

        // PLL never acknowledges -> timeout
        pll_dead = 1'b1;
        repeat (2) @(negedge clk100);
        start = 1'b1;
        @(negedge clk100);
        start = 1'b0;
        wait_step(1'b1, "step_rise3");
        n = 0;
        while (error !== 1'b1 && n < 400) begin
            @(negedge clk100);
            n++;
        end
        $display("timeout after %0d cycles in STEP_ACK", n);
        chk("tmo_cycles", 32'(n), 255);
        chk("tmo_error", 32'(error), 1);
        chk("tmo_step", 32'(pll_phasestep), 0);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_valid", 32'(result_valid), 0);
        start = 1'b1;
        repeat (20) @(negedge clk100);
        start = 1'b0;
        chk("start_blocked", 32'(busy), 0);
        chk("error_sticky", 32'(error), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phase_sweep_ctrl.md
PHASE_SWEEP_CTRL -- requirements
Module: phase_sweep_ctrl

Interface
REQ-001 Parameter MAX_STEPS, default 128, is the number of phase positions per sweep and the result width (legal range 2..255).
REQ-002 Parameter SETTLE_CYCLES, default 64, is the number of idle clk100 cycles after a phase shift completes before sampling (legal range 1..255).
REQ-003 Parameter PLL_TIMEOUT, default 255, is the maximum number of clk100 cycles spent in each PLL wait state.
REQ-004 clk100  in  1  is the single clock; scanclk and the capture logic share it.
REQ-005 reset_n  in  1  is an asynchronous, active-low reset (driven from PLL locked).
REQ-006 start  in  1  requests one sweep; it is sampled only in IDLE.
REQ-007 pll_phasestep  out  1  is the phase-step request to the PLL.
REQ-008 pll_phaseupdown  out  1  selects the shift direction: 1 = up (later), 0 = down.
REQ-009 pll_phasedone  in  1  is the PLL done flag: high when idle, low while a shift is in progress.
REQ-010 sample_req  out  1  is a one-cycle pulse requesting an echo capture at the current phase.
REQ-011 sample_ack  in  1  is a one-cycle pulse; sample_bit is valid in the same cycle.
REQ-012 sample_bit  in  1  is the captured echo level.
REQ-013 result  out  MAX_STEPS  is the sweep bit vector; bit i holds the sample taken at phase index i.
REQ-014 result_valid  out  1  indicates result is complete and stable.
REQ-015 result_ready  in  1  is the consumer accept (serial dumper).
REQ-016 step_idx  out  8  is the current phase index relative to the sweep origin.
REQ-017 busy  out  1  is high in every state except IDLE.
REQ-018 error  out  1  is a sticky PLL-timeout flag.

Function
REQ-019 The block SHALL implement the states IDLE, SAMPLE, WAIT_SAMPLE, STEP_REQ, STEP_ACK, STEP_DONE, SETTLE, RETURN and DONE.
REQ-020 IDLE: start=1 and error=0 -> SAMPLE; result_valid=0; step_idx=0.
REQ-021 SAMPLE: pulse sample_req for 1 cycle -> WAIT_SAMPLE.
REQ-022 WAIT_SAMPLE: on sample_ack, write result[step_idx]=sample_bit; if step_idx==MAX_STEPS-1 -> RETURN, else -> STEP_REQ with pll_phaseupdown=1.
REQ-023 STEP_REQ: assert pll_phasestep and hold it until pll_phasedone is sampled low, then deassert it -> STEP_DONE; this path passes through STEP_ACK.
REQ-024 STEP_DONE: wait for pll_phasedone high; then step_idx +/-1 according to pll_phaseupdown -> SETTLE (forward) or RETURN (return path).
REQ-025 SETTLE: count SETTLE_CYCLES cycles -> SAMPLE.
REQ-026 RETURN: while step_idx!=0, issue a down-shift via STEP_REQ/STEP_DONE with pll_phaseupdown=0; when step_idx==0 -> DONE.
REQ-027 pll_phaseupdown SHALL be stable from 1 cycle before pll_phasestep rises until pll_phasedone returns high.
REQ-028 DONE: result_valid=1 and result frozen; result_valid&&result_ready in the same cycle -> IDLE, with result_valid dropping the next cycle.
REQ-029 Each of STEP_ACK and STEP_DONE SHALL time out after PLL_TIMEOUT cycles: error=1, pll_phasestep=0 -> IDLE, with result_valid staying 0.
REQ-030 error SHALL be cleared only by reset; start is ignored while error=1.
REQ-031 A sample_ack outside WAIT_SAMPLE SHALL be ignored.
REQ-032 A start pulse during a sweep SHALL be ignored and SHALL NOT be queued.
REQ-033 step_idx SHALL never exceed MAX_STEPS-1 and SHALL never wrap below 0.

Reset
REQ-034 While reset_n=0: state=IDLE, pll_phasestep=0, pll_phaseupdown=0, sample_req=0, result=0, result_valid=0, step_idx=0, busy=0, error=0, and all counters=0.
REQ-035 When reset is asserted mid-shift, pll_phasestep SHALL drop immediately (asynchronously); the origin phase is not restored.
REQ-036 After reset is released, the first state transition SHALL occur no earlier than the second rising clk100 edge.

Configuration
REQ-037 The macro PHASE_SWEEP_BIDIR_EN SHALL select between two sweep modes, as defined in REQ-038 and REQ-039.
REQ-038 With PHASE_SWEEP_BIDIR_EN undefined, RETURN restores the origin after every sweep.
REQ-039 With PHASE_SWEEP_BIDIR_EN defined, RETURN is omitted and a direction bit toggles each sweep; the reverse sweep starts at index MAX_STEPS-1 and stores descending indices with down-shifts, so the end is the origin.

Verification
REQ-040 MAX_STEPS=4, PLL model with a 3-cycle done latency, sample_bit=idx[0] -> result=4'b1010, 3 up-shifts then 3 down-shifts, result_valid=1.
REQ-041 In DONE, hold result_ready=0 for 10 cycles -> result stable and valid held; result_ready=1 -> IDLE on the next cycle.
REQ-042 PLL model never lowers pll_phasedone -> error=1 after 255 cycles in STEP_ACK, pll_phasestep=0, and a subsequent start is ignored.
REQ-043 Assert reset_n=0 during STEP_DONE -> pll_phasestep=0 and all outputs at reset values in the same cycle.
REQ-044 Pulse start while busy, plus a spurious sample_ack in SETTLE -> no result change and no second sweep.
REQ-045 With PHASE_SWEEP_BIDIR_EN, run two sweeps with MAX_STEPS=4 -> the second sweep issues only down-shifts and has no RETURN phase.
